hz_esig: RTL and testbench



---
 rtl/hz_esig_pkg.sv | 8 +
 rtl/mod_n_counter.sv | 26 ++
 rtl/hz_esig.sv | 32 +++
 tb/tb_hz_esig.sv | 83 ++++++++
 4 files changed

// File: rtl/hz_esig_pkg.sv
// hz_esig_pkg: shared defaults and counter-width helper for the enable-strobe generator.
package hz_esig_pkg;
  localparam int SYS_CLK_HZ = 100_000_000;
  localparam int ONE_HZ = 1;
  function automatic int div_width(input int divisor);
    return (divisor < 2) ? 1 : $clog2(divisor);
  endfunction
endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: free-running 0..N-1 counter with a registered flag high while count == N-1.
module mod_n_counter
  import hz_esig_pkg::*;
#(
  parameter int N = 2,
  parameter int W = div_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] count,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [W-1:0] nxt;
  always_comb nxt = (count == LAST) ? '0 : count + W'(1);
  // tc looks ahead at nxt so it is a flop that is high in the same cycle count sits at LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= nxt;
      tc    <= (nxt == LAST);
    end
  end
endmodule

// File: rtl/hz_esig.sv
// hz_esig: divides clk to a one-cycle enable strobe every CLK_HZ/OUT_HZ cycles (truncated).
module hz_esig
  import hz_esig_pkg::*;
#(
  parameter int CLK_HZ = SYS_CLK_HZ,
  parameter int OUT_HZ = ONE_HZ
) (
  input  logic clk,
  input  logic reset,
  output logic enable
);
  localparam int DIVISOR = CLK_HZ / ((OUT_HZ == 0) ? 1 : OUT_HZ);
  if (CLK_HZ < 1 || OUT_HZ < 1 || OUT_HZ > CLK_HZ) begin : g_bad
    $error("hz_esig: illegal CLK_HZ=%0d OUT_HZ=%0d", CLK_HZ, OUT_HZ);
  end
  if (DIVISOR <= 1) begin : g_div1
    // strobe every cycle: no counter needed, enable simply comes up after the first edge
    always_ff @(posedge clk or posedge reset) begin
      if (reset) enable <= 1'b0;
      else enable <= 1'b1;
    end
  end else begin : g_div
    localparam int CW = div_width(DIVISOR);
    logic [CW-1:0] unused_count;
    mod_n_counter #(.N(DIVISOR), .W(CW)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .count(unused_count),
      .tc   (enable)
    );
  end
endmodule

// File: tb/tb_hz_esig.sv
// tb_hz_esig: scoreboard bench for hz_esig at divisors 10, 3 (truncated), 1 and 2.
module tb_hz_esig;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic e10, e3, e1, e2;
  int total = 0;
  int bad = 0;
  int k = 0;
  logic [3:0] sb[$];

  hz_esig #(.CLK_HZ(10), .OUT_HZ(1)) u10 (.clk(clk), .reset(reset), .enable(e10));
  hz_esig #(.CLK_HZ(7),  .OUT_HZ(2)) u3  (.clk(clk), .reset(reset), .enable(e3));
  hz_esig #(.CLK_HZ(5),  .OUT_HZ(5)) u1  (.clk(clk), .reset(reset), .enable(e1));
  hz_esig #(.CLK_HZ(4),  .OUT_HZ(2)) u2  (.clk(clk), .reset(reset), .enable(e2));

  always #5 clk = ~clk;

  function automatic logic model(input int d, input int n);
    return (n >= 1) && (n % d == d - 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] exp);
    check({tag, "/div10"}, int'(e10), int'(exp[3]));
    check({tag, "/div3"},  int'(e3),  int'(exp[2]));
    check({tag, "/div1"},  int'(e1),  int'(exp[1]));
    check({tag, "/div2"},  int'(e2),  int'(exp[0]));
  endtask

  task automatic step(input string tag);
    logic [3:0] exp;
    if (!reset) k++;
    sb.push_back(reset ? 4'b0 : {model(10, k), model(3, k), k >= 1 ? 1'b1 : 1'b0, model(2, k)});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check_all(tag, exp);
  endtask

  initial begin
    int p3, p10;
    p3 = 0;
    p10 = 0;
    #1;
    check_all("reset_initial", 4'b0);
    repeat (3) step("in_reset");
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      step("run1");
      p3 += int'(e3);
      p10 += int'(e10);
    end
    check("div3_pulses_30", p3, 10);
    for (int i = 0; i < 10; i++) begin
      step("run1");
      p10 += int'(e10);
    end
    check("div10_pulses_40", p10, 4);
    repeat (9) step("to_strobe");
    check("div10_high_before_abort", int'(e10), 1);
    #2;
    reset = 1'b1;
    k = 0;
    #1;
    check_all("async_abort", 4'b0);
    sb.delete();
    repeat (2) step("reheld");
    @(negedge clk);
    reset = 1'b0;
    repeat (22) step("run2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
